// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the buffered UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_NONE2
  } parity_t;

  // Only the even/odd encodings add a parity bit; both "none" codes skip it.
  function automatic logic parity_active(input parity_t p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy count, async active-low reset
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; count is unchanged on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter; parity via UART_TX_PARITY_EN
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic [1:0]                    cfg_parity,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int BCW        = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam int BIW        = $clog2(DATA_BITS);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;

  state_t               state;
  logic [BCW-1:0]       baud_cnt;
  logic [BIW-1:0]       bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_q;
  logic                 par_bit_q;

  logic                 baud_done;
  logic                 stop_done;
  logic                 load_par_en;
  logic                 load_par_bit;

  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state != IDLE);
  assign baud_done = (baud_cnt == BCW'(BAUD_TICKS - 1));
  assign stop_done = baud_done && (stop_idx == 1'(STOP_BITS - 1));
  // A new frame is taken either from idle or seamlessly at the end of the last stop bit.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && stop_done));

`ifdef UART_TX_PARITY_EN
  assign load_par_en  = parity_active(parity_t'(cfg_parity));
  assign load_par_bit = (parity_t'(cfg_parity) == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
  assign load_par_en       = 1'b0;
  assign load_par_bit      = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencer with inline baud divider; tx is registered and parity mode is latched per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shreg     <= fifo_rdata;
            par_en_q  <= load_par_en;
            par_bit_q <= load_par_bit;
            baud_cnt  <= '0;
            state     <= START;
            tx        <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == BIW'(DATA_BITS - 1)) begin
              if (par_en_q) begin
                tx    <= par_bit_q;
                state <= PARITY;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (stop_done) begin
              if (fifo_pop) begin
                shreg     <= fifo_rdata;
                par_en_q  <= load_par_en;
                par_bit_q <= load_par_bit;
                state     <= START;
                tx        <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered (8N1 and 7-bit/2-stop instances)
module tb_uart_tx_buffered;

  localparam int BT = 10;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [1:0] cfg;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic [1:0] cfg_parity = 2'b00;
  logic       tx;
  logic       tx_busy;
  logic [4:0] fifo_count;

  logic       tx_valid2 = 1'b0;
  logic       tx_ready2;
  logic [6:0] tx_data2 = '0;
  logic       tx2;
  logic       tx_busy2;
  logic [4:0] fifo_count2;

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_unexpected = 0;
  item_t sb[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cfg_parity(cfg_parity), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  uart_tx_buffered #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .cfg_parity(2'b00), .tx(tx2), .tx_busy(tx_busy2), .fifo_count(fifo_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit par_on(input logic [1:0] cfg);
    return PAR_BUILD && (cfg == 2'b01 || cfg == 2'b10);
  endfunction

  function automatic int frame_clks(input logic [1:0] cfg);
    return BT * (10 + (par_on(cfg) ? 1 : 0));
  endfunction

  // Line monitor: every low level on tx starts a frame that must match the oldest queued word.
  item_t       mon_it;
  logic [15:0] exp_bits;
  logic [15:0] got_bits;
  int          nbits;
  int          bad;
  int          idle_cnt = 0;
  bit          expect_b2b = 1'b0;
  bit          aborted;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        expect_b2b = 1'b0;
        idle_cnt   = 0;
        continue;
      end
      if (tx !== 1'b0) begin
        idle_cnt++;
        continue;
      end
      if (expect_b2b) check_eq("b2b_gap", idle_cnt, 0);
      if (sb.size() == 0) begin
        n_unexpected++;
        continue;
      end
      mon_it   = sb.pop_front();
      exp_bits = '0;
      for (int i = 0; i < 8; i++) exp_bits[1+i] = mon_it.data[i];
      nbits = 9;
      if (par_on(mon_it.cfg)) begin
        exp_bits[nbits] = (mon_it.cfg == 2'b10) ? ~^mon_it.data : ^mon_it.data;
        nbits++;
      end
      exp_bits[nbits] = 1'b1;
      nbits++;
      got_bits = '0;
      bad      = 0;
      aborted  = 1'b0;
      for (int k = 0; k < nbits * BT; k++) begin
        if (k > 0) @(negedge clk);
        if (!rst_n) begin
          aborted = 1'b1;
          break;
        end
        if (tx !== exp_bits[k/BT]) bad++;
        if (k % BT == BT / 2) got_bits[k/BT] = tx;
      end
      if (aborted) begin
        sb.delete();
        expect_b2b = 1'b0;
        idle_cnt   = 0;
        continue;
      end
      check_eq("frame_bits", got_bits, exp_bits);
      check_eq("bit_timing", bad, 0);
      expect_b2b = (sb.size() > 0);
      idle_cnt   = 0;
    end
  end

  // Hold tx_valid high and offer n words; records how many were taken before the first refusal.
  task automatic send_burst(input int n, input logic [7:0] base, output int first_stall);
    int   i = 0;
    int   budget = 0;
    logic rdy;
    first_stall = -1;
    while (i < n && budget < 5000) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = base + 8'(i * 29);
      rdy      = tx_ready;
      if (!rdy && first_stall < 0) first_stall = i;
      @(posedge clk);
      if (rdy) begin
        sb.push_back('{data: tx_data, cfg: cfg_parity});
        i++;
      end
      budget++;
    end
    check_eq("burst_accept_all", i, n);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Push one word into an idle transmitter and time the start latency and busy window.
  task automatic send_one(input logic [7:0] d, input logic [1:0] cfg, input string tag);
    int   stall;
    int   cnt = 0;
    logic first_tx = 1'b1;
    cfg_parity = cfg;
    send_burst(1, d, stall);
    check_eq({tag, "_pre_start_tx"}, tx, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) first_tx = tx;
      if (tx_busy) cnt++;
      else break;
    end
    check_eq({tag, "_latency_tx"}, first_tx, 1'b0);
    check_eq({tag, "_busy_clks"}, cnt, frame_clks(cfg));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while ((sb.size() != 0 || tx_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_drained"}, (c < budget), 1'b1);
  endtask

  int stall;
  int lows;
  int busy2;
  int first_low;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_one(8'hA5, 2'b00, "a5_8n1");
    send_one(8'h07, 2'b01, "p07_even");
    send_one(8'h07, 2'b10, "p07_odd");
    for (int r = 0; r < 4; r++) send_one(8'($urandom), 2'($urandom_range(0, 3)), "rand");
    repeat (5) @(negedge clk);

    cfg_parity = 2'b00;
    send_burst(20, 8'h30, stall);
    check_eq("burst_first_stall", stall, 17);
    wait_idle(3000, "burst");
    check_eq("unexpected_frames", n_unexpected, 0);
    repeat (5) @(negedge clk);

    send_burst(4, 8'h51, stall);
    check_eq("pre_reset_count", fifo_count, 3);
    repeat (33) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", tx, 1'b1);
    check_eq("midrst_count", fifo_count, 0);
    check_eq("midrst_busy", tx_busy, 1'b0);
    check_eq("midrst_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("post_reset_quiet", lows, 0);

    @(negedge clk);
    tx_valid2 = 1'b1;
    tx_data2  = 7'h7F;
    @(posedge clk);
    @(negedge clk);
    tx_valid2 = 1'b0;
    lows      = 0;
    busy2     = 0;
    first_low = -1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (tx2 === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
      if (tx_busy2) busy2++;
    end
    check_eq("d7s2_first_low", first_low, 0);
    check_eq("d7s2_low_clks", lows, BT);
    check_eq("d7s2_busy_clks", busy2, 100);
    check_eq("d7s2_final_tx", tx2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
